// File: rtl/truth_table_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer_pkg
// Shared definitions for the truth-table sequencer:
//   state_t    - sequencer FSM encoding (IDLE/DRIVE/DONE)
//   clog2_min1 - ceil(log2(value)), never less than 1, for sizing counters
// -----------------------------------------------------------------------------
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width needed to count 0..value-1; a 1-cycle dwell still gets a 1-bit counter.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts the cycles an input vector has been held.
//   clk    - system clock
//   rst    - synchronous active-high reset
//   clear  - force the count back to 0 (start of a run)
//   en     - count this cycle
//   expire - high on the last cycle of each dwell (count == DWELL_CYCLES-1
//            while enabled); the count reloads to 0 on that same edge
// -----------------------------------------------------------------------------
module dwell_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = clog2_min1(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign expire = en & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
// Steps a combinational gate through every input combination in ascending
// order, holds each for DWELL_CYCLES clocks and captures the gate output at
// the end of each dwell into a truth-table register.
//   clk         - system clock, all state changes on rising edge
//   rst         - synchronous active-high reset
//   start       - run request, only looked at while idle (not queued)
//   gate_o      - output of the gate under test
//   vec         - registered gate input vector (MSB drives gate input i0)
//   busy        - high while vectors are applied
//   done        - one-cycle pulse when a run completes
//   truth_table - bit k = gate_o captured while vec == k
//   dbg_state   - current sequencer state
// -----------------------------------------------------------------------------
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_INPUTS     = 2,
  parameter int DWELL_CYCLES = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       gate_o,
  output logic [N_INPUTS-1:0]        vec,
  output logic                       busy,
  output logic                       done,
  output logic [(1<<N_INPUTS)-1:0]   truth_table,
  output state_t                     dbg_state
);

  localparam int N_VEC = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] LAST_VEC = '1;

  state_t              r_state;
  logic [N_INPUTS-1:0] r_vec;
  logic                r_busy;
  logic                r_done;
  logic [N_VEC-1:0]    r_tt;

  logic w_accept;
  logic w_drive;
  logic w_expire;

  assign w_accept = (r_state == ST_IDLE) & start;
  assign w_drive  = (r_state == ST_DRIVE);

  // Clearing on the accepting edge makes the first dwell start at count 0.
  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (w_accept),
    .en    (w_drive),
    .expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_vec  <= '0;
          r_busy <= 1'b0;
          if (start) begin
            r_state <= ST_DRIVE;
            r_busy  <= 1'b1;
            r_tt    <= '0;
          end
        end
        ST_DRIVE: begin
          if (w_expire) begin
            r_tt[r_vec] <= gate_o;
            // Terminal vector is detected explicitly, so vec never wraps.
            if (r_vec == LAST_VEC) begin
              r_state <= ST_DONE;
              r_vec   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_vec   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vec         = r_vec;
  assign busy        = r_busy;
  assign done        = r_done;
  assign truth_table = r_tt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sequencer
// Two sequencers share one clock: dut4 (DWELL_CYCLES=4) and dut1
// (DWELL_CYCLES=1), both with N_INPUTS=2. The gate under test is modelled
// here as AND (gate_sel=0) or OR (gate_sel=1) of the vector.
// Snapshots are {vec, busy, done, truth_table, state}, sampled 1 ns after
// each rising edge; cycle c means "after edge S+c".
// -----------------------------------------------------------------------------
module tb_truth_table_sequencer;
  import truth_table_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic       start1 = 1'b0;
  logic       gate_sel = 1'b0;

  logic [1:0] vec4, vec1;
  logic       busy4, busy1, done4, done1;
  logic [3:0] tt4, tt1;
  state_t     st4, st1;
  logic       gate4, gate1;

  assign gate4 = gate_sel ? (|vec4) : (&vec4);
  assign gate1 = gate_sel ? (|vec1) : (&vec1);

  truth_table_sequencer #(.N_INPUTS(2), .DWELL_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .gate_o(gate4),
    .vec(vec4), .busy(busy4), .done(done4), .truth_table(tt4), .dbg_state(st4)
  );

  truth_table_sequencer #(.N_INPUTS(2), .DWELL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_o(gate1),
    .vec(vec1), .busy(busy1), .done(done1), .truth_table(tt1), .dbg_state(st1)
  );

  logic [9:0] snap4, snap1;
  assign snap4 = {vec4, busy4, done4, tt4, st4};
  assign snap1 = {vec1, busy1, done1, tt1, st1};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gate_fn(logic gsel, int k);
    return gsel ? (k != 0) : (k == 3);
  endfunction

  // Expected snapshot c cycles after the start-sampling edge of one run.
  function automatic logic [9:0] exp_snap(int dwell, int c, logic gsel);
    logic [1:0] v;
    logic       b, d;
    logic [3:0] tt;
    logic [1:0] st;
    int         t;
    t = 4 * dwell;
    v = 2'd0; b = 1'b0; d = 1'b0; tt = 4'd0; st = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (((k + 1) * dwell <= c) || (c >= t)) tt[k] = gate_fn(gsel, k);
    end
    if (c < t) begin
      v = 2'(c / dwell); b = 1'b1; st = 2'd1;
    end else if (c == t) begin
      d = 1'b1; st = 2'd2;
    end
    return {v, b, d, tt, st};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
    tick(); tick();
    n_checks++;
    if (snap4 !== 10'd0) $display("FAIL reset_dut4 got %b exp %b", snap4, 10'd0);
    else n_pass++;
    n_checks++;
    if (snap1 !== 10'd0) $display("FAIL reset_dut1 got %b exp %b", snap1, 10'd0);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (snap4 !== 10'd0) $display("FAIL idle_after_reset got %b exp %b", snap4, 10'd0);
    else n_pass++;
  endtask

  // One full dut4 run; extra start pulses are sampled at edges S+p1/p2/p3.
  task automatic run4(string name, logic gsel, logic [3:0] exp_final,
                      int p1, int p2, int p3);
    int ndone;
    logic [9:0] e;
    ndone = 0;
    gate_sel = gsel;
    start4 = 1'b1;
    tick();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        start4 = (c == p1) || (c == p2) || (c == p3);
        tick();
      end
      e = exp_snap(4, c, gsel);
      n_checks++;
      if (snap4 !== e)
        $display("FAIL %s c=%0d {vec,busy,done,tt,state} got %b exp %b", name, c, snap4, e);
      else n_pass++;
      if (done4) ndone++;
    end
    start4 = 1'b0;
    n_checks++;
    if (ndone !== 1) $display("FAIL %s_done_count got %0d exp 1", name, ndone);
    else n_pass++;
    n_checks++;
    if (tt4 !== exp_final) $display("FAIL %s_table got %b exp %b", name, tt4, exp_final);
    else n_pass++;
  endtask

  task automatic test_and();
    run4("and_run", 1'b0, 4'b1000, -1, -1, -1);
  endtask

  task automatic test_or_then_and();
    run4("or_run", 1'b1, 4'b1110, -1, -1, -1);
    run4("and_rerun", 1'b0, 4'b1000, -1, -1, -1);
  endtask

  task automatic test_ignored_start();
    run4("ignored_start", 1'b0, 4'b1000, 5, 16, 17);
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] e;
    gate_sel = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      e = exp_snap(4, c, 1'b1);
      n_checks++;
      if (snap4 !== e)
        $display("FAIL mid_run c=%0d {vec,busy,done,tt,state} got %b exp %b", c, snap4, e);
      else n_pass++;
    end
    n_checks++;
    if (tt4 !== 4'b0010) $display("FAIL mid_run_table got %b exp %b", tt4, 4'b0010);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (snap4 !== 10'd0) $display("FAIL reset_mid_run got %b exp %b", snap4, 10'd0);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({busy4, done4} !== 2'b00)
        $display("FAIL after_reset_quiet c=%0d {busy,done} got %b exp 00", c, {busy4, done4});
      else n_pass++;
    end
    run4("after_reset_run", 1'b0, 4'b1000, -1, -1, -1);
  endtask

  task automatic test_dwell_one();
    logic [9:0] e;
    gate_sel = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) tick();
      e = exp_snap(1, c, 1'b0);
      n_checks++;
      if (snap1 !== e)
        $display("FAIL dwell_one c=%0d {vec,busy,done,tt,state} got %b exp %b", c, snap1, e);
      else n_pass++;
    end
    n_checks++;
    if (tt1 !== 4'b1000) $display("FAIL dwell_one_table got %b exp %b", tt1, 4'b1000);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    int ndone, nlow, cr;
    ndone = 0; nlow = 0;
    gate_sel = 1'b0;
    start4 = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) tick();
      // Runs start at S, S+18 and S+36 while start stays high.
      cr = (c >= 36) ? c - 36 : (c >= 18) ? c - 18 : c;
      e = exp_snap(4, cr, 1'b0);
      n_checks++;
      if (snap4 !== e)
        $display("FAIL back_to_back c=%0d {vec,busy,done,tt,state} got %b exp %b", c, snap4, e);
      else n_pass++;
      if (done4) ndone++;
      if (c >= 1 && c <= 33 && !busy4) nlow++;
    end
    start4 = 1'b0;
    n_checks++;
    if (ndone !== 2) $display("FAIL back_to_back_done_count got %0d exp 2", ndone);
    else n_pass++;
    n_checks++;
    if (nlow !== 2) $display("FAIL back_to_back_busy_gap got %0d exp 2", nlow);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (snap4 !== 10'd0) $display("FAIL back_to_back_cleanup got %b exp %b", snap4, 10'd0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_and();
    test_or_then_and();
    test_ignored_start();
    test_reset_mid_run();
    test_dwell_one();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
